uart_mem_dump: RTL and testbench

//  UART transmit side of the program-loader link: reads WORD_COUNT 32-bit words from word-addressed

---
 rtl/uart_mem_dump.sv | 142 ++++++++++++++
 tb/tb_uart_mem_dump.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_dump.sv
// uart_mem_dump
//   Program-loader UART transmit side. Reads word_count 32-bit words from a
//   word-addressed sync RAM, starting at address 0. Each word is sent as 4
//   bytes (word[7:0] first), each byte as an 8N1 frame with bit 0 first, so a
//   dump re-loads bit-exactly through the loader's receive side.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : dump request, sampled only while idle
//   word_count  : number of words to send, latched when start is accepted
//   rd_en       : one-cycle read strobe per word
//   rd_addr     : word address qualified by rd_en (0,1,2,...)
//   rd_data     : read data, valid the cycle after rd_en
//   uart_tx     : serial line, idle high
//   busy        : high whenever the FSM is not idle
//   done        : one-cycle pulse when a dump completes (or word_count==0)
module uart_mem_dump #(
  parameter int CLKS_PER_BIT = 10418,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int          TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]        state;
  logic [TW-1:0]     tmr;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       sh;      // current word, shifted right one bit per data bit
  logic [ADDR_W-1:0] cnt;     // latched word_count

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      cnt      <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (start) begin
            cnt <= word_count;
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              state   <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              busy    <= 1'b1;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        // RAM output is valid now; capture it and open the first start bit.
        S_WAIT: begin
          sh       <= rd_data;
          uart_tx  <= 1'b0;
          tmr      <= '0;
          byte_idx <= '0;
          state    <= S_START;
        end
        S_START: begin
          if (tmr == TMAX) begin
            tmr     <= '0;
            uart_tx <= sh[0];
            sh      <= sh >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (tmr == TMAX) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              uart_tx <= sh[0];
              sh      <= sh >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_STOP: begin
          if (tmr == TMAX) begin
            tmr <= '0;
            if (byte_idx != 2'd3) begin
              // next byte of the same word follows back-to-back
              byte_idx <= byte_idx + 1'b1;
              uart_tx  <= 1'b0;
              state    <= S_START;
            end else if (rd_addr != cnt - ADDR_W'(1)) begin
              // FETCH + WAIT leave the line high for two extra cycles
              rd_addr <= rd_addr + ADDR_W'(1);
              rd_en   <= 1'b1;
              state   <= S_FETCH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: main instance at CLKS_PER_BIT=4 with a UART
// receiver monitor popping expected bytes from a scoreboard queue, plus a
// CLKS_PER_BIT=2 instance checked cycle-by-cycle on its line pattern.
module tb_uart_mem_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] wc, wc2;
  logic        rd_en, rd_en2;
  logic [31:0] rd_addr, rd_addr2;
  logic [31:0] rd_data, rd_data2;
  logic        uart_tx, uart_tx2;
  logic        busy, busy2;
  logic        done, done2;

  always #5 clk = ~clk;

  uart_mem_dump #(.CLKS_PER_BIT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(wc),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .uart_tx(uart_tx), .busy(busy), .done(done));

  uart_mem_dump #(.CLKS_PER_BIT(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .word_count(wc2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .uart_tx(uart_tx2), .busy(busy2), .done(done2));

  // sync RAM models, 1-cycle read latency
  logic [31:0] mem [0:15];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];
  always @(posedge clk) if (rd_en2) rd_data2 <= 32'h8000_0001;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  exp_q [$];
  logic [31:0] rd_log [$];
  int          gaps [$];
  int          nstarts = 0;
  int          cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (rd_en) rd_log.push_back(rd_addr);

  // UART receiver: samples each bit in its centre (cycle 2 of 4)
  logic       prev_tx = 1'b1;
  bit         mbusy = 1'b0;
  int         mcnt = 0;
  int         last_start = 0;
  logic [7:0] mbyte = '0;
  logic [7:0] eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      mbusy = 1'b0;
    end else if (!mbusy) begin
      if (prev_tx && !uart_tx) begin
        mbusy = 1'b1;
        mcnt  = 0;
        nstarts++;
        if (nstarts > 1) gaps.push_back(cycle - last_start);
        last_start = cycle;
      end
    end else begin
      mcnt++;
      if (mcnt == 2) chk("start_bit", 32'(uart_tx), 32'd0);
      else if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2) mbyte = {uart_tx, mbyte[7:1]};
      else if (mcnt == 38) begin
        chk("stop_bit", 32'(uart_tx), 32'd1);
        chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          chk("rx_byte", 32'(mbyte), 32'(eb));
        end
        mbusy = 1'b0;
      end
    end
    prev_tx = uart_tx;
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  // Pulse start, optionally re-pulse with word_count=7 at cycle rp, wait for
  // done (bounded). cyc=1 is the first negedge after the accepting edge.
  task automatic run_dump(input logic [31:0] n, input int rp, input int limit,
                          output int cyc, output logic busy1);
    @(negedge clk); start = 1'b1; wc = n;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    busy1 = busy;
    while (!done && cyc < limit) begin
      @(negedge clk); cyc++;
      start = (cyc == rp);
      if (cyc == rp) wc = 32'd7;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          cyc, s0, g0;
  logic        b1;
  logic [9:0]  pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; wc = '0; start2 = 1'b0; wc2 = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_rd_en",   32'(rd_en),   32'd0);
    chk("rst_rd_addr", rd_addr,      32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_uart_tx2", 32'(uart_tx2), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // word_count = 0: done next cycle, nothing else moves
    rd_log.delete(); s0 = nstarts;
    run_dump(32'd0, 0, 20, cyc, b1);
    chk("wc0_cycles", 32'(cyc), 32'd1);
    chk("wc0_busy", 32'(b1), 32'd0);
    chk("wc0_no_rd", 32'(rd_log.size()), 32'd0);
    chk("wc0_no_frames", 32'(nstarts - s0), 32'd0);

    // single word
    mem[0] = 32'h1234_5678;
    push_word(32'h1234_5678);
    rd_log.delete(); s0 = nstarts;
    run_dump(32'd1, 0, 400, cyc, b1);
    chk("w1_busy", 32'(b1), 32'd1);
    chk("w1_cycles", 32'(cyc - 1), 32'd162);
    chk("w1_rd_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) chk("w1_rd_addr", rd_log[0], 32'd0);
    chk("w1_frames", 32'(nstarts - s0), 32'd4);
    chk("w1_q_empty", 32'(exp_q.size()), 32'd0);

    // three words, gap pattern between frames
    mem[0] = 32'hA5A5_A5A5; mem[1] = 32'h0000_0000; mem[2] = 32'hFFFF_FFFF;
    push_word(mem[0]); push_word(mem[1]); push_word(mem[2]);
    rd_log.delete(); s0 = nstarts; g0 = gaps.size();
    run_dump(32'd3, 0, 800, cyc, b1);
    chk("w3_cycles", 32'(cyc - 1), 32'd486);
    chk("w3_rd_count", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++) chk("w3_rd_addr", rd_log[i], 32'(i));
    chk("w3_frames", 32'(nstarts - s0), 32'd12);
    chk("w3_gap_count", 32'(gaps.size() - g0), 32'd12);
    for (int i = 0; i < 11 && (g0 + 1 + i) < gaps.size(); i++)
      chk("w3_gap", 32'(gaps[g0 + 1 + i]), ((i % 4) == 3) ? 32'd42 : 32'd40);
    chk("w3_q_empty", 32'(exp_q.size()), 32'd0);

    // start re-pulsed mid-transfer is ignored
    mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h0F1E_2D3C;
    push_word(mem[0]); push_word(mem[1]);
    rd_log.delete(); s0 = nstarts;
    run_dump(32'd2, 50, 800, cyc, b1);
    chk("rp_cycles", 32'(cyc - 1), 32'd324);
    chk("rp_rd_count", 32'(rd_log.size()), 32'd2);
    chk("rp_frames", 32'(nstarts - s0), 32'd8);
    chk("rp_q_empty", 32'(exp_q.size()), 32'd0);

    // async reset during data bit 3 of byte 1
    mem[0] = 32'h0000_0055;
    exp_q.push_back(8'h55);
    @(negedge clk); start = 1'b1; wc = 32'd1;
    @(negedge clk); start = 1'b0;
    repeat (58) @(negedge clk);
    chk("pre_rst_line_low", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(uart_tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_addr", rd_addr, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_byte0_seen", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_word(32'h0000_0055);
    rd_log.delete(); s0 = nstarts;
    run_dump(32'd1, 0, 400, cyc, b1);
    chk("post_rst_cycles", 32'(cyc - 1), 32'd162);
    chk("post_rst_rd_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) chk("post_rst_addr", rd_log[0], 32'd0);
    chk("post_rst_frames", 32'(nstarts - s0), 32'd4);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    // CLKS_PER_BIT=2, word 0x80000001: exact byte0 line pattern
    pat = 10'b10_0000_0010;
    @(negedge clk); start2 = 1'b1; wc2 = 32'd1;
    @(negedge clk); start2 = 1'b0;
    cyc = 1;
    @(negedge clk); cyc++;
    chk("cpb2_pre_start", 32'(uart_tx2), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cyc++;
      chk("cpb2_line", 32'(uart_tx2), 32'(pat[i / 2]));
    end
    while (!done2 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    chk("cpb2_done", 32'(done2), 32'd1);
    chk("cpb2_cycles", 32'(cyc - 1), 32'd82);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
